// File: rtl/hamming_pkg.sv
// Shared SECDED helpers: code geometry and bit-position classification.
package hamming_pkg;

    // Smallest P with 2^P >= data_w + P + 1 (condition is monotone in P).
    function automatic int unsigned calc_par_w(input int unsigned data_w);
        int unsigned p;
        p = 1;
        for (int unsigned i = 1; i < 8; i++) begin
            if ((32'd1 << i) < data_w + i + 1) p = i + 1;
        end
        return p;
    endfunction

    // Hamming bits plus the overall parity bit at position 0.
    function automatic int unsigned calc_code_w(input int unsigned data_w);
        return data_w + calc_par_w(data_w) + 1;
    endfunction

    // Positions 1, 2, 4, ... carry Hamming parity.
    function automatic logic is_parity_pos(input int unsigned pos);
        return (pos != 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Code-word position of payload bit j (payload fills non-parity slots from 3 upward).
    function automatic int unsigned data_pos(input int unsigned j);
        int unsigned cnt;
        int unsigned res;
        cnt = 0;
        res = 0;
        for (int unsigned pos = 3; pos < 128; pos++) begin
            if (!is_parity_pos(pos)) begin
                if (cnt == j) res = pos;
                cnt++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder: syndrome, classification and single-bit correction.
module hamming_secded_dec
    import hamming_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CODE_W = calc_code_w(DATA_W),
    localparam int unsigned IDX_W = $clog2(CODE_W)
) (
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data,
    output logic [IDX_W-1:0]  error_index,
    output logic              single_error,
    output logic              double_error
);

    logic [IDX_W-1:0]  syndrome;
    logic              overall;
    logic [CODE_W-1:0] fixed;

    // Syndrome/overall parity, classify, flip the located bit, extract payload.
    always_comb begin
        syndrome = '0;
        for (int unsigned i = 1; i < CODE_W; i++) begin
            if (code[IDX_W'(i)]) syndrome = syndrome ^ IDX_W'(i);
        end
        overall      = ^code;
        single_error = 1'b0;
        double_error = 1'b0;
        error_index  = '0;
        if (syndrome == '0) begin
            // Error confined to the overall parity bit: payload untouched.
            single_error = overall;
        end else if (overall && ({1'b0, syndrome} < (IDX_W + 1)'(CODE_W))) begin
            single_error = 1'b1;
            error_index  = syndrome;
        end else begin
            double_error = 1'b1;
        end
        fixed = code;
        for (int unsigned i = 1; i < CODE_W; i++) begin
            if (single_error && (syndrome == IDX_W'(i))) fixed[IDX_W'(i)] = ~code[IDX_W'(i)];
        end
        data = '0;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            data[j] = fixed[IDX_W'(data_pos(j))];
        end
    end

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage SECDED pipeline: encode + error injection, then decode/correct, with
// valid/ready handshaking and saturating single/double error counters.
module hamming_secded_pipe
    import hamming_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned PAR_W = calc_par_w(DATA_W),
    localparam int unsigned CODE_W = calc_code_w(DATA_W),
    localparam int unsigned IDX_W = $clog2(CODE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] raw_data,
    input  logic [CODE_W-1:0] error_inject,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] received_code,
    output logic [DATA_W-1:0] corrected_data,
    output logic [IDX_W-1:0]  error_index,
    output logic              single_error,
    output logic              double_error,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  single_cnt,
    output logic [CNT_W-1:0]  double_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CODE_W-1:0] enc_code;
    logic              enc_par;
    logic              s1_valid_q;
    logic [CODE_W-1:0] s1_code_q;
    logic              s2_load;
    logic              accept;
    logic              handoff;
    logic [DATA_W-1:0] dec_data;
    logic [IDX_W-1:0]  dec_index;
    logic              dec_single;
    logic              dec_double;
    logic              out_valid_q;
    logic [CODE_W-1:0] rx_code_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  index_q;
    logic              single_q;
    logic              double_q;
    logic [CNT_W-1:0]  single_cnt_q;
    logic [CNT_W-1:0]  double_cnt_q;

    // Handshake: stage 2 frees up on handoff, stage 1 may refill in the same cycle.
    always_comb begin
        s2_load  = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_load;
        accept   = in_valid && in_ready;
        handoff  = out_valid_q && out_ready;
    end

    // Encoder: place payload, then each Hamming bit evens out its index class.
    always_comb begin
        enc_code = '0;
        enc_par  = 1'b0;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            enc_code[IDX_W'(data_pos(j))] = raw_data[j];
        end
        for (int unsigned k = 0; k < PAR_W; k++) begin
            enc_par = 1'b0;
            for (int unsigned i = 1; i < CODE_W; i++) begin
                if (((i >> k) & 1) != 0) enc_par = enc_par ^ enc_code[IDX_W'(i)];
            end
            enc_code[IDX_W'(1 << k)] = enc_par;
        end
        enc_code[0] = ^enc_code[CODE_W-1:1];
    end

    // Stage 1: capture encoded word with channel errors applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_code_q  <= enc_code ^ error_inject;
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    hamming_secded_dec #(
        .DATA_W(DATA_W)
    ) u_dec (
        .code        (s1_code_q),
        .data        (dec_data),
        .error_index (dec_index),
        .single_error(dec_single),
        .double_error(dec_double)
    );

    // Stage 2: result registers, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rx_code_q   <= '0;
            data_q      <= '0;
            index_q     <= '0;
            single_q    <= 1'b0;
            double_q    <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rx_code_q <= s1_code_q;
                data_q    <= dec_data;
                index_q   <= dec_index;
                single_q  <= dec_single;
                double_q  <= dec_double;
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            single_cnt_q <= '0;
            double_cnt_q <= '0;
        end else if (clr_cnt) begin
            single_cnt_q <= '0;
            double_cnt_q <= '0;
        end else if (handoff) begin
            if (single_q && (single_cnt_q != CntMax)) single_cnt_q <= single_cnt_q + 1'b1;
            if (double_q && (double_cnt_q != CntMax)) double_cnt_q <= double_cnt_q + 1'b1;
        end
    end

    assign out_valid      = out_valid_q;
    assign received_code  = rx_code_q;
    assign corrected_data = data_q;
    assign error_index    = index_q;
    assign single_error   = single_q;
    assign double_error   = double_q;
    assign single_cnt     = single_cnt_q;
    assign double_cnt     = double_cnt_q;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Scoreboard bench for hamming_secded_pipe (DATA_W=8, CNT_W=4).
module tb_hamming_secded_pipe;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int CODE_W = 13;
    localparam int IDX_W  = 4;
    localparam int CMAX   = 15;

    typedef struct {
        logic [CODE_W-1:0] code;
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              se;
        logic              de;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] raw_data = '0;
    logic [CODE_W-1:0] error_inject = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CODE_W-1:0] received_code;
    logic [DATA_W-1:0] corrected_data;
    logic [IDX_W-1:0]  error_index;
    logic              single_error;
    logic              double_error;
    logic              clr_cnt = 1'b0;
    logic [CNT_W-1:0]  single_cnt;
    logic [CNT_W-1:0]  double_cnt;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   m_single = 0;
    int   m_double = 0;
    logic hold_prev = 1'b0;
    logic [CODE_W-1:0] prev_code;
    logic [DATA_W-1:0] prev_data;
    logic rnd_bp = 1'b0;

    hamming_secded_pipe #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .raw_data      (raw_data),
        .error_inject  (error_inject),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .received_code (received_code),
        .corrected_data(corrected_data),
        .error_index   (error_index),
        .single_error  (single_error),
        .double_error  (double_error),
        .clr_cnt       (clr_cnt),
        .single_cnt    (single_cnt),
        .double_cnt    (double_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference encoding: Hamming bits chosen so the data-bit position XOR cancels.
    function automatic logic [CODE_W-1:0] ref_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int j;
        int s;
        c = '0;
        j = 0;
        s = 0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[j];
                if (d[j]) s = s ^ pos;
                j++;
            end
        end
        for (int k = 0; (1 << k) < CODE_W; k++) c[1 << k] = s[k];
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] ref_extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int j;
        j = 0;
        d = '0;
        for (int pos = 1; pos < CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = c[pos];
                j++;
            end
        end
        return d;
    endfunction

    // Expected result from the number of injected flips (0, 1 or 2).
    function automatic exp_t ref_model(input logic [DATA_W-1:0] d, input logic [CODE_W-1:0] inj);
        exp_t e;
        e.code = ref_encode(d) ^ inj;
        e.data = d;
        e.idx  = '0;
        e.se   = 1'b0;
        e.de   = 1'b0;
        if ($countones(inj) == 1) begin
            e.se = 1'b1;
            for (int p = 0; p < CODE_W; p++) if (inj[p]) e.idx = IDX_W'(p);
        end else if ($countones(inj) == 2) begin
            e.de   = 1'b1;
            e.data = ref_extract(e.code);
        end
        return e;
    endfunction

    task automatic send(input logic [DATA_W-1:0] d, input logic [CODE_W-1:0] inj);
        int w;
        in_valid     = 1'b1;
        raw_data     = d;
        error_inject = inj;
        for (w = 0; w < 200; w++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (w == 200) check("accept_timeout", 64'd0, 64'd1);
        else sb.push_back(ref_model(d, inj));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [CODE_W-1:0] rand_inject(input int weight);
        logic [CODE_W-1:0] m;
        int p1;
        int p2;
        m  = '0;
        p1 = $urandom_range(0, CODE_W - 1);
        p2 = p1;
        while (p2 == p1) p2 = $urandom_range(0, CODE_W - 1);
        if (weight >= 1) m[p1] = 1'b1;
        if (weight >= 2) m[p2] = 1'b1;
        return m;
    endfunction

    task automatic drain();
        int w;
        for (w = 0; w < 500 && sb.size() != 0; w++) @(posedge clk);
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Random backpressure when enabled.
    always @(posedge clk) begin
        if (rnd_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: stability under stall, scoreboard pop on handoff, counter model.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_code", 64'(received_code), 64'(prev_code));
                check("hold_data", 64'(corrected_data), 64'(prev_data));
            end
            hold_prev = out_valid && !out_ready;
            prev_code = received_code;
            prev_data = corrected_data;
            check("single_cnt", 64'(single_cnt), 64'(m_single));
            check("double_cnt", 64'(double_cnt), 64'(m_double));
            e.se = 1'b0;
            e.de = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("received_code", 64'(received_code), 64'(e.code));
                    check("corrected_data", 64'(corrected_data), 64'(e.data));
                    check("error_index", 64'(error_index), 64'(e.idx));
                    check("single_error", 64'(single_error), 64'(e.se));
                    check("double_error", 64'(double_error), 64'(e.de));
                end
            end
            if (clr_cnt) begin
                m_single = 0;
                m_double = 0;
            end else begin
                if (e.se && m_single < CMAX) m_single++;
                if (e.de && m_double < CMAX) m_double++;
            end
        end
    end

    initial begin
        // Reset state.
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_code", 64'(received_code), 64'd0);
        check("rst_flags", 64'({single_error, double_error, error_index}), 64'd0);
        check("rst_cnts", 64'({single_cnt, double_cnt}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Clean word, with latency check.
        send(8'hA5, 13'h0);
        check("lat_cycle1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_cycle2", 64'(out_valid), 64'd1);
        check("a5_data", 64'(corrected_data), 64'hA5);
        drain();

        // Single errors at bit 5 and bit 0, double error at bits 3 and 6.
        send(8'h3C, 13'h0020);
        send(8'h3C, 13'h0001);
        send(8'h3C, 13'h0048);
        drain();
        check("dbl_single_cnt", 64'(single_cnt), 64'd2);
        check("dbl_double_cnt", 64'(double_cnt), 64'd1);

        // Stall: two words fit, third is refused until release.
        out_ready = 1'b0;
        send(8'h11, 13'h0);
        send(8'h22, 13'h0004);
        in_valid = 1'b1;
        raw_data = 8'h33;
        error_inject = 13'h0;
        repeat (4) begin
            @(negedge clk);
            check("in_ready_blocked", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h33, 13'h0);
        drain();

        // Saturation of single_cnt, then clear racing an increment.
        for (int i = 0; i < 20; i++) send(8'($urandom), rand_inject(1));
        drain();
        check("single_sat", 64'(single_cnt), 64'd15);
        send(8'h5A, 13'h0100);
        @(posedge clk);
        #1;
        check("clr_race_valid", 64'(out_valid), 64'd1);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_priority", 64'(single_cnt), 64'd0);
        drain();

        // Randomised traffic with random backpressure.
        rnd_bp = 1'b1;
        for (int i = 0; i < 300; i++) send(8'($urandom), rand_inject($urandom_range(0, 2)));
        rnd_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(8'hC3, 13'h0);
        send(8'h3C, 13'h0002);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_flush_valid", 64'(out_valid), 64'd0);
        sb.delete();
        m_single = 0;
        m_double = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst2", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_stale_word", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
